// File: rtl/dcache_control.sv
`default_nettype none
// ============================================================================
// dcache_control : hit / writeback / allocate sequencer and saturating perf
//                  counters for a two-way write-back write-allocate L1 dcache
// Revision       : 1.0
// ============================================================================
module dcache_control #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 mem_read,
    input  logic                 mem_write,
    output logic                 mem_resp,
    output logic                 pmem_read,
    output logic                 pmem_write,
    input  logic                 pmem_resp,
    input  logic                 cache_hit,
    input  logic                 dirtyout,
    output logic                 write_enable,
    output logic                 cache_allocate,
    output logic                 datain_mux_sel,
    output logic                 valid_in,
    output logic                 dirty_datain,
    output logic                 pmem_address_sel,
    output logic                 addr_reg_load,
    input  logic                 perf_clear,
    output logic [CNT_WIDTH-1:0] hit_count,
    output logic [CNT_WIDTH-1:0] miss_count,
    output logic [CNT_WIDTH-1:0] wb_count
);
    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WRITEBACK = 2'd1,
        ST_ALLOCATE  = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic                 miss_pending_q, miss_pending_d;
    logic [CNT_WIDTH-1:0] hit_cnt_q, hit_cnt_d;
    logic [CNT_WIDTH-1:0] miss_cnt_q, miss_cnt_d;
    logic [CNT_WIDTH-1:0] wb_cnt_q, wb_cnt_d;

    logic w_req;
    logic w_mem_resp, w_pmem_read, w_pmem_write, w_write_enable, w_cache_allocate;
    logic w_datain_mux_sel, w_valid_in, w_dirty_datain, w_pmem_address_sel, w_addr_reg_load;
    logic w_hit_inc, w_miss_inc, w_wb_inc;

    function automatic logic [CNT_WIDTH-1:0] sat_next(input logic [CNT_WIDTH-1:0] cnt,
                                                      input logic inc, input logic clr);
        if (clr) return '0;
        if (inc && (cnt != {CNT_WIDTH{1'b1}})) return cnt + 1'b1;
        return cnt;
    endfunction

    assign w_req = mem_read | mem_write;

    always_comb begin
        state_d            = state_q;
        miss_pending_d     = miss_pending_q;
        w_mem_resp         = 1'b0;
        w_pmem_read        = 1'b0;
        w_pmem_write       = 1'b0;
        w_write_enable     = 1'b0;
        w_cache_allocate   = 1'b0;
        w_datain_mux_sel   = 1'b0;
        w_valid_in         = 1'b0;
        w_dirty_datain     = 1'b0;
        w_pmem_address_sel = 1'b0;
        w_addr_reg_load    = 1'b0;
        w_miss_inc         = 1'b0;
        w_wb_inc           = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (w_req) begin
                    if (cache_hit) begin
                        w_mem_resp = 1'b1;
                        // A simultaneous read+write is handled as a write
                        if (mem_write) begin
                            w_write_enable   = 1'b1;
                            w_datain_mux_sel = 1'b1;
                            w_valid_in       = 1'b1;
                            w_dirty_datain   = 1'b1;
                        end
                    end else begin
                        w_addr_reg_load = 1'b1;
                        miss_pending_d  = 1'b1;
                        w_miss_inc      = 1'b1;
                        state_d         = dirtyout ? ST_WRITEBACK : ST_ALLOCATE;
                    end
                end else begin
                    // Request abandoned during the miss: nothing left to retry
                    miss_pending_d = 1'b0;
                end
            end
            ST_WRITEBACK: begin
                w_pmem_write       = 1'b1;
                w_pmem_address_sel = 1'b1;
                if (pmem_resp) begin
                    w_wb_inc = 1'b1;
                    state_d  = ST_ALLOCATE;
                end
            end
            ST_ALLOCATE: begin
                w_pmem_read = 1'b1;
                if (pmem_resp) begin
                    w_write_enable   = 1'b1;
                    w_cache_allocate = 1'b1;
                    w_valid_in       = 1'b1;
                    state_d          = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        w_hit_inc = w_mem_resp & ~miss_pending_q;
        if (w_mem_resp) miss_pending_d = 1'b0;

        hit_cnt_d  = sat_next(hit_cnt_q, w_hit_inc, perf_clear);
        miss_cnt_d = sat_next(miss_cnt_q, w_miss_inc, perf_clear);
        wb_cnt_d   = sat_next(wb_cnt_q, w_wb_inc, perf_clear);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= ST_IDLE;
            miss_pending_q <= 1'b0;
            hit_cnt_q      <= '0;
            miss_cnt_q     <= '0;
            wb_cnt_q       <= '0;
        end else begin
            state_q        <= state_d;
            miss_pending_q <= miss_pending_d;
            hit_cnt_q      <= hit_cnt_d;
            miss_cnt_q     <= miss_cnt_d;
            wb_cnt_q       <= wb_cnt_d;
        end
    end

    // Outputs are forced low while reset is held, even though they are Mealy
    assign mem_resp         = reset_n & w_mem_resp;
    assign pmem_read        = reset_n & w_pmem_read;
    assign pmem_write       = reset_n & w_pmem_write;
    assign write_enable     = reset_n & w_write_enable;
    assign cache_allocate   = reset_n & w_cache_allocate;
    assign datain_mux_sel   = reset_n & w_datain_mux_sel;
    assign valid_in         = reset_n & w_valid_in;
    assign dirty_datain     = reset_n & w_dirty_datain;
    assign pmem_address_sel = reset_n & w_pmem_address_sel;
    assign addr_reg_load    = reset_n & w_addr_reg_load;
    assign hit_count        = hit_cnt_q;
    assign miss_count       = miss_cnt_q;
    assign wb_count         = wb_cnt_q;
endmodule
`default_nettype wire

// File: tb/tb_dcache_control.sv
`default_nettype none
// ============================================================================
// tb_dcache_control : randomized transaction bench with per-cycle scoreboard
// Revision          : 1.0
// ============================================================================
module tb_dcache_control;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_n, mem_read, mem_write, pmem_resp, cache_hit, dirtyout, perf_clear;
    logic mem_resp, pmem_read, pmem_write, write_enable, cache_allocate;
    logic datain_mux_sel, valid_in, dirty_datain, pmem_address_sel, addr_reg_load;
    logic [15:0] hit_count, miss_count, wb_count;
    logic s_mem_resp, s_pmem_read, s_pmem_write, s_write_enable, s_cache_allocate;
    logic s_datain_mux_sel, s_valid_in, s_dirty_datain, s_pmem_address_sel, s_addr_reg_load;
    logic [3:0] s_hit_count, s_miss_count, s_wb_count;

    dcache_control #(.CNT_WIDTH(16)) dut (
        .clk(clk), .reset_n(reset_n), .mem_read(mem_read), .mem_write(mem_write),
        .mem_resp(mem_resp), .pmem_read(pmem_read), .pmem_write(pmem_write),
        .pmem_resp(pmem_resp), .cache_hit(cache_hit), .dirtyout(dirtyout),
        .write_enable(write_enable), .cache_allocate(cache_allocate),
        .datain_mux_sel(datain_mux_sel), .valid_in(valid_in), .dirty_datain(dirty_datain),
        .pmem_address_sel(pmem_address_sel), .addr_reg_load(addr_reg_load),
        .perf_clear(perf_clear), .hit_count(hit_count), .miss_count(miss_count),
        .wb_count(wb_count)
    );

    // Narrow-counter copy on the same stimulus exposes saturation quickly
    dcache_control #(.CNT_WIDTH(4)) dut_s (
        .clk(clk), .reset_n(reset_n), .mem_read(mem_read), .mem_write(mem_write),
        .mem_resp(s_mem_resp), .pmem_read(s_pmem_read), .pmem_write(s_pmem_write),
        .pmem_resp(pmem_resp), .cache_hit(cache_hit), .dirtyout(dirtyout),
        .write_enable(s_write_enable), .cache_allocate(s_cache_allocate),
        .datain_mux_sel(s_datain_mux_sel), .valid_in(s_valid_in), .dirty_datain(s_dirty_datain),
        .pmem_address_sel(s_pmem_address_sel), .addr_reg_load(s_addr_reg_load),
        .perf_clear(perf_clear), .hit_count(s_hit_count), .miss_count(s_miss_count),
        .wb_count(s_wb_count)
    );

    typedef struct packed {
        logic resp, we, alloc, mux, vin, din, pr, pw, sel, arl;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    bit   mon_en  = 1'b0;
    int   m_hit = 0, m_miss = 0, m_wb = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: one expected output vector per cycle, compared mid-cycle
    always @(negedge clk) begin
        if (mon_en) begin
            exp_t e, o;
            o = '{mem_resp, write_enable, cache_allocate, datain_mux_sel, valid_in,
                  dirty_datain, pmem_read, pmem_write, pmem_address_sel, addr_reg_load};
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL scoreboard_empty cyc %0d got %b", cyc, o);
            end else begin
                e = exp_q.pop_front();
                if (o !== e) begin
                    n_fail++;
                    $display("FAIL outputs cyc %0d got %b exp %b (resp we alloc mux vin din pr pw sel arl)",
                             cyc, o, e);
                end
            end
        end
    end

    function automatic int sat(input int v, input int w);
        int mx;
        mx = (1 << w) - 1;
        return (v > mx) ? mx : v;
    endfunction

    function automatic exp_t v_idle();
        exp_t e;
        e = '0;
        return e;
    endfunction

    function automatic exp_t v_resp(input bit wr);
        exp_t e;
        e = '0;
        e.resp = 1'b1;
        if (wr) begin e.we = 1'b1; e.mux = 1'b1; e.vin = 1'b1; e.din = 1'b1; end
        return e;
    endfunction

    function automatic exp_t v_miss();
        exp_t e;
        e = '0;
        e.arl = 1'b1;
        return e;
    endfunction

    function automatic exp_t v_wb();
        exp_t e;
        e = '0;
        e.pw = 1'b1; e.sel = 1'b1;
        return e;
    endfunction

    function automatic exp_t v_alloc(input bit fill);
        exp_t e;
        e = '0;
        e.pr = 1'b1;
        if (fill) begin e.we = 1'b1; e.alloc = 1'b1; e.vin = 1'b1; end
        return e;
    endfunction

    task automatic chk(input string nm, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s got %0d exp %0d", nm, got, exp);
        end
    endtask

    task automatic check_counters();
        chk("hit_count",    int'(hit_count),    sat(m_hit, 16));
        chk("miss_count",   int'(miss_count),   sat(m_miss, 16));
        chk("wb_count",     int'(wb_count),     sat(m_wb, 16));
        chk("hit_count_w4", int'(s_hit_count),  sat(m_hit, 4));
        chk("miss_count_w4", int'(s_miss_count), sat(m_miss, 4));
        chk("wb_count_w4",  int'(s_wb_count),   sat(m_wb, 4));
    endtask

    task automatic clear_model();
        m_hit = 0; m_miss = 0; m_wb = 0;
    endtask

    task automatic tick(input exp_t e);
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input bit allow_clr);
        for (int i = 0; i < n; i++) begin
            mem_read   = 1'b0;
            mem_write  = 1'b0;
            pmem_resp  = 1'b0;
            cache_hit  = 1'(($urandom));
            dirtyout   = 1'(($urandom));
            perf_clear = allow_clr && ($urandom_range(0, 9) == 0);
            if (perf_clear) clear_model();
            tick(v_idle());
        end
        perf_clear = 1'b0;
    endtask

    // One CPU access from request to completion; nw/na are pmem latencies
    task automatic txn(input bit wr, input bit both, input bit hit, input bit dirty,
                       input int nw, input int na, input bit drop, input bit clr);
        check_counters();
        mem_write = wr;
        mem_read  = !wr || both;
        cache_hit = hit;
        dirtyout  = dirty;
        pmem_resp = 1'b0;
        if (hit) begin
            perf_clear = clr;
            if (clr) clear_model(); else m_hit++;
            tick(v_resp(wr));
            perf_clear = 1'b0;
        end else begin
            m_miss++;
            tick(v_miss());
            if (drop) begin mem_read = 1'b0; mem_write = 1'b0; end
            if (dirty) begin
                for (int k = 0; k <= nw; k++) begin
                    cache_hit = 1'(($urandom));
                    dirtyout  = 1'(($urandom));
                    pmem_resp = (k == nw);
                    if (k == nw) m_wb++;
                    tick(v_wb());
                end
            end
            for (int k = 0; k <= na; k++) begin
                cache_hit = 1'(($urandom));
                dirtyout  = 1'(($urandom));
                pmem_resp = (k == na);
                tick(v_alloc(k == na));
            end
            pmem_resp = 1'b0;
            if (!drop) begin
                cache_hit = 1'b1;
                tick(v_resp(wr));
            end
        end
        idle($urandom_range(1, 3), 1'b1);
    endtask

    initial begin
        reset_n = 1'b0; mem_read = 1'b1; mem_write = 1'b0; cache_hit = 1'b1;
        dirtyout = 1'b0; pmem_resp = 1'b0; perf_clear = 1'b0;
        @(posedge clk);
        #1;
        mon_en = 1'b1;
        check_counters();
        tick(v_idle());
        tick(v_idle());
        reset_n = 1'b1;
        m_hit++;
        tick(v_resp(1'b0));
        idle(2, 1'b0);

        txn(1'b0, 1'b0, 1'b1, 1'b0, 0, 0, 1'b0, 1'b0);
        txn(1'b1, 1'b0, 1'b1, 1'b0, 0, 0, 1'b0, 1'b0);
        txn(1'b1, 1'b1, 1'b1, 1'b0, 0, 0, 1'b0, 1'b0);
        txn(1'b0, 1'b0, 1'b0, 1'b0, 0, 3, 1'b0, 1'b0);
        txn(1'b1, 1'b0, 1'b0, 1'b1, 2, 2, 1'b0, 1'b0);
        txn(1'b0, 1'b0, 1'b0, 1'b1, 0, 0, 1'b1, 1'b0);

        // Hit burst drives the 4-bit counter into saturation, then clear on a hit
        for (int i = 0; i < 20; i++) txn(1'(($urandom)), 1'b0, 1'b1, 1'b0, 0, 0, 1'b0, 1'b0);
        txn(1'b0, 1'b0, 1'b1, 1'b0, 0, 0, 1'b0, 1'b1);

        for (int i = 0; i < 80; i++) begin
            bit hit;
            hit = 1'(($urandom));
            txn(1'(($urandom)), ($urandom_range(0, 3) == 0), hit, 1'(($urandom)),
                $urandom_range(0, 4), $urandom_range(0, 4),
                !hit && ($urandom_range(0, 5) == 0),
                hit && ($urandom_range(0, 5) == 0));
        end

        // Asynchronous reset in the middle of a line fill
        check_counters();
        mem_read = 1'b1; mem_write = 1'b0; cache_hit = 1'b0; dirtyout = 1'b0;
        m_miss++;
        tick(v_miss());
        tick(v_alloc(1'b0));
        tick(v_alloc(1'b0));
        reset_n = 1'b0;
        #1;
        chk("pmem_read_in_reset", int'(pmem_read), 0);
        chk("pmem_write_in_reset", int'(pmem_write), 0);
        clear_model();
        check_counters();
        mem_read = 1'b0;
        tick(v_idle());
        reset_n = 1'b1;
        idle(2, 1'b0);
        check_counters();

        chk("scoreboard_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
